// File: rtl/tmr_wdt_prescaler_pkg.sv
// Purpose: shared OPTION bit positions, prescaler sizing and helpers for TMR0/WDT.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package tmr_wdt_prescaler_pkg;

    localparam int OPT_T0CS       = 5;
    localparam int OPT_T0SE       = 4;
    localparam int OPT_PSA        = 3;
    localparam int OPT_PS_MSB     = 2;
    localparam int OPT_PS_LSB     = 0;

    localparam int PRESCALER_W    = 8;
    localparam int INHIBIT_CYCLES = 2;
    localparam int INHIBIT_W      = 2;

    // True when val[msb:0] are all ones, i.e. the next count carries out of bit msb.
    function automatic logic low_bits_set(input logic [PRESCALER_W-1:0] val,
                                          input logic [2:0]             msb);
        logic [PRESCALER_W:0] mask;
        mask = (PRESCALER_W+1)'(2) << msb;
        mask = mask - (PRESCALER_W+1)'(1);
        return (val & mask[PRESCALER_W-1:0]) == mask[PRESCALER_W-1:0];
    endfunction

endpackage

// File: rtl/tmr_wdt_prescaler_t0cki_sync.sv
// Purpose: synchronise the asynchronous T0CKI pin and emit a 1-clock pulse on the selected edge.
// Latency: pin change to pulse is SYNC_STAGES clocks; pulse is combinational from flops.
// Backpressure: none; every qualifying edge produces exactly one pulse.
module t0cki_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    input  logic i_falling,
    output logic o_edge_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Shift the pin through the synchroniser and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_last <= w_synced;
        end
    end

    assign o_edge_pulse = i_falling ? (r_last & ~w_synced) : (~r_last & w_synced);

endmodule

// File: rtl/tmr_wdt_prescaler.sv
// Purpose: TMR0 counter, watchdog and the shared prescaler that can serve either one.
// Latency: internal source increments TMR0 next edge; T0CKI pin to tmr_out is SYNC_STAGES+1 clocks.
// Backpressure: none; events are never stalled, a TMR0 write simply takes priority over counting.
module tmr_wdt_prescaler
    import tmr_wdt_prescaler_pkg::*;
#(
    parameter int TMR_W       = 8,
    parameter int WDT_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cyc_en,
    input  logic [5:0]       option_in,
    input  logic             t0cki,
    input  logic             sleep,
    input  logic             wdt_en,
    input  logic             tmr_wr,
    input  logic [TMR_W-1:0] tmr_wdata,
    input  logic             clear_wdt,
    input  logic             clear_prescaler,
    input  logic             tmr_if_clr,
    output logic [TMR_W-1:0] tmr_out,
    output logic             tmr_if,
    output logic             wdt_timeout
);

    logic                   w_t0cs;
    logic                   w_t0se;
    logic                   w_psa;
    logic [2:0]             w_ps;
    logic                   w_ext_pulse;
    logic                   w_src_evt;
    logic                   w_wdt_tick;
    logic                   w_psc_tick;
    logic                   w_psc_cnt;
    logic                   w_psc_clr;
    logic                   w_final_tick;
    logic                   w_timeout;
    logic                   w_tmr_inc;
    logic                   w_inh_busy;
    logic                   w_tmr_wrap;

    logic [3:0]             r_opt_prev;
    logic [WDT_W-1:0]       r_wdt_base;
    logic [PRESCALER_W-1:0] r_psc;
    logic [TMR_W-1:0]       r_tmr;
    logic [INHIBIT_W-1:0]   r_inhibit;
    logic                   r_tmr_if;
    logic                   r_wdt_timeout;

    assign w_t0cs = option_in[OPT_T0CS];
    assign w_t0se = option_in[OPT_T0SE];
    assign w_psa  = option_in[OPT_PSA];
    assign w_ps   = option_in[OPT_PS_MSB:OPT_PS_LSB];

    t0cki_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_t0cki_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pin        (t0cki),
        .i_falling    (w_t0se),
        .o_edge_pulse (w_ext_pulse)
    );

    // External edges keep counting in sleep; the instruction clock does not.
    assign w_src_evt  = w_t0cs ? w_ext_pulse : (cyc_en & ~sleep);
    assign w_wdt_tick = wdt_en & (&r_wdt_base);

    // Prescaler carry-out: bit PS when serving TMR0, bit PS-1 (or bypass at PS=0) when serving WDT.
    always_comb begin
        w_psc_tick = 1'b0;
        if (w_psa) begin
            if (w_ps == 3'd0) begin
                w_psc_tick = w_wdt_tick;
            end else begin
                w_psc_tick = w_wdt_tick & low_bits_set(r_psc, w_ps - 3'd1);
            end
        end else begin
            w_psc_tick = w_src_evt & low_bits_set(r_psc, w_ps);
        end
    end

    assign w_psc_cnt    = w_psa ? w_wdt_tick : w_src_evt;
    assign w_final_tick = w_psa ? w_psc_tick : w_wdt_tick;
    assign w_timeout    = w_final_tick & ~clear_wdt;

    // Any reassignment or rescaling restarts the prescaler so the new ratio starts clean.
    assign w_psc_clr = clear_prescaler
                     | (r_opt_prev != {w_psa, w_ps})
                     | (tmr_wr & ~w_psa)
                     | (clear_wdt & w_psa)
                     | w_timeout;

    assign w_tmr_inc  = w_psa ? w_src_evt : w_psc_tick;
    assign w_inh_busy = (r_inhibit != '0);
    assign w_tmr_wrap = w_tmr_inc & ~tmr_wr & ~w_inh_busy & (&r_tmr);

    // Remember the last PSA/PS setting so a change can be spotted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opt_prev <= '0;
        end else begin
            r_opt_prev <= {w_psa, w_ps};
        end
    end

    // Watchdog base counter: free-runs while enabled, held at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt_base <= '0;
        end else if (!wdt_en || clear_wdt) begin
            r_wdt_base <= '0;
        end else begin
            r_wdt_base <= r_wdt_base + WDT_W'(1);
        end
    end

    // Shared prescaler: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc <= '0;
        end else if (w_psc_clr) begin
            r_psc <= '0;
        end else if (w_psc_cnt) begin
            r_psc <= r_psc + PRESCALER_W'(1);
        end
    end

    // TMR0: a write loads and arms the inhibit; inhibited increments only drain the inhibit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr     <= '0;
            r_inhibit <= '0;
        end else if (tmr_wr) begin
            r_tmr     <= tmr_wdata;
            r_inhibit <= INHIBIT_W'(INHIBIT_CYCLES);
        end else if (w_tmr_inc) begin
            if (w_inh_busy) begin
                r_inhibit <= r_inhibit - INHIBIT_W'(1);
            end else begin
                r_tmr <= r_tmr + TMR_W'(1);
            end
        end
    end

    // Sticky overflow flag: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_if <= 1'b0;
        end else if (w_tmr_wrap) begin
            r_tmr_if <= 1'b1;
        end else if (tmr_if_clr) begin
            r_tmr_if <= 1'b0;
        end
    end

    // One-cycle timeout pulse, suppressed when CLRWDT lands on the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt_timeout <= 1'b0;
        end else begin
            r_wdt_timeout <= w_timeout;
        end
    end

    assign tmr_out     = r_tmr;
    assign tmr_if      = r_tmr_if;
    assign wdt_timeout = r_wdt_timeout;

endmodule

// File: doc/tmr_wdt_prescaler.md
Name: tmr_wdt_prescaler

Overview:
Parametrised successor to the PIC16C57 TMR0/WDT/prescaler logic, fed by the OPTION register and the control unit's clear strobes.
- One shared prescaler that can be assigned to either TMR0 or the watchdog.
- Configurable timer and watchdog widths.
- New versus the 16C57: a sticky TMR0 overflow flag for the successor core's interrupt logic, an on-chip T0CKI synchroniser, and a 2-tick increment inhibit after a TMR0 write.

Parameters:
- TMR_W, 8, TMR0 width in bits.
- WDT_W, 10, watchdog base counter width; one WDT tick per 2^WDT_W enabled clocks.
- SYNC_STAGES, 2, T0CKI synchroniser flop count (>=2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- cyc_en  in  1  instruction-cycle enable; qualifies the internal timer source
- option_in  in  6  OPTION[5:0]: [5]T0CS, [4]T0SE, [3]PSA, [2:0]PS
- t0cki  in  1  external timer clock, asynchronous
- sleep  in  1  core in SLEEP
- wdt_en  in  1  watchdog enable (fuse)
- tmr_wr  in  1  write strobe for TMR0
- tmr_wdata  in  TMR_W  TMR0 write data
- clear_wdt  in  1  CLRWDT/SLEEP strobe from the control unit
- clear_prescaler  in  1  prescaler clear strobe from the control unit
- tmr_if_clr  in  1  clear overflow flag
- tmr_out  out  TMR_W  TMR0 value
- tmr_if  out  1  sticky overflow flag
- wdt_timeout  out  1  one-cycle watchdog timeout pulse

Behaviour:
- Reset clears everything: tmr_out=0, tmr_if=0, wdt_timeout=0, prescaler=0, WDT base=0, inhibit count=0, synchroniser and edge flops=0.
- Timer source event (src_evt):
  - T0CS=0: src_evt = cyc_en & ~sleep.
  - T0CS=1: src_evt = one-clock pulse on the synchronised t0cki edge. Rising edge when T0SE=0, falling when T0SE=1.
  - The edge is detected by comparing the last synchroniser stage with one extra registered copy. Pin change to tmr_out change is SYNC_STAGES+1 clocks (3 by default).
  - External counting continues in sleep.
- Prescaler: one 8-bit up-counter. Output tick is a carry out of bit k.
  - PSA=0 (assigned to TMR0): counts on src_evt; k=PS, giving a 1:2^(PS+1) ratio; TMR0 increments on the tick.
  - PSA=1 (assigned to WDT): counts on WDT base ticks; k=PS-1, giving 1:2^PS; PS=0 bypasses (1:1). TMR0 increments directly on src_evt.
- Prescaler clears, all at the next edge:
  - on clear_prescaler;
  - on any change of PSA or PS;
  - on tmr_wr when PSA=0;
  - on clear_wdt when PSA=1.
- TMR0:
  - tmr_wr loads tmr_wdata next edge and sets the inhibit counter to 2. Each subsequent increment event decrements inhibit instead of incrementing TMR0.
  - tmr_wr in the same cycle as an increment: write wins.
  - Counting wraps from 2^TMR_W-1 to 0 and sets tmr_if.
- tmr_if:
  - Sticky until tmr_if_clr.
  - Simultaneous set and clear: set wins.
  - tmr_wr never sets the flag.
- Watchdog:
  - WDT base counts every clock while wdt_en, including during sleep. Its wrap from all-ones to 0 is one WDT tick.
  - Final tick = WDT tick (PSA=0) or prescaler output tick (PSA=1).
  - Final tick drives wdt_timeout=1 for exactly one cycle.
  - The base continues from 0, and the prescaler is cleared on timeout.
- clear_wdt clears the WDT base (and the prescaler if PSA=1). When it coincides with a final tick, the clear wins and no pulse is produced.
- wdt_en=0 holds the WDT base at 0; wdt_timeout stays 0.
- Asynchronous reset mid-count returns all state to reset values immediately. There is no pending pulse after release.

Decomposition:
- Shared package holds:
  - OPTION bit index constants: T0CS=5, T0SE=4, PSA=3, PS_MSB=2, PS_LSB=0;
  - PRESCALER_W=8;
  - INHIBIT_CYCLES=2.
- One sub-module: t0cki_sync (SYNC_STAGES flop chain plus edge detector with polarity select, producing a 1-clock pulse).
- Prescaler, TMR0 and WDT stay in the top level.

Test Plan:
- T0CS=0, PSA=1, cyc_en=1 constant, TMR_W=8 -> tmr_out increments each clock; 255->0 at clock 256 sets tmr_if; tmr_if_clr on the same cycle as a later overflow leaves tmr_if=1.
- T0CS=0, PSA=0, PS=2 (1:8) -> tmr_out steps once per 8 cycles; writing 0xF0 reloads, clears the prescaler, and the next two ticks are swallowed so the first increment lands on the 3rd tick.
- T0CS=1, T0SE=1, toggle t0cki at 1/10 clk -> tmr_out increments only on falling edges, 3 clocks after each pin fall.
- WDT_W=4, PSA=1, PS=3 (1:8), wdt_en=1 -> single-cycle wdt_timeout every 128 clocks, including with sleep=1; clear_wdt at clock 100 delays the next pulse to clock 228.
- clear_wdt coincident with a final tick -> no pulse; PSA toggle mid-count -> prescaler returns to 0 next edge.
- rst_n low mid-count with tmr_out=0x37 and tmr_if=1 -> all outputs 0 immediately, counting resumes from 0 after release.
